// File: rtl/vga_pkg.sv
// ----------------------------------------------------------------------------
// vga_pkg
// Shared constants and types for the SVGA 800x600@56 Hz timing generator:
// default raster timing, counter width, lock-qualification FSM states and the
// colour-bar palette used by the optional test pattern (VGA_TEST_PATTERN_EN).
// No ports (package).
// ----------------------------------------------------------------------------
package vga_pkg;

   localparam int CNT_W = 11;

   // 800x600@56 Hz with a 36 MHz pixel clock: 1024 clocks/line, 625 lines/frame
   localparam int H_ACTIVE = 800;
   localparam int H_FP     = 24;
   localparam int H_SYNC   = 72;
   localparam int H_BP     = 128;
   localparam int V_ACTIVE = 600;
   localparam int V_FP     = 1;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 22;

   localparam logic HS_POL = 1'b1;
   localparam logic VS_POL = 1'b1;

   localparam int LOCK_SETTLE = 1024;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      SETTLE    = 2'd1,
      RUN       = 2'd2
   } lock_state_e;

   // 4 bits per channel, {R,G,B}
   localparam logic [11:0] RGB_WHITE   = 12'hFFF;
   localparam logic [11:0] RGB_YELLOW  = 12'hFF0;
   localparam logic [11:0] RGB_CYAN    = 12'h0FF;
   localparam logic [11:0] RGB_GREEN   = 12'h0F0;
   localparam logic [11:0] RGB_MAGENTA = 12'hF0F;
   localparam logic [11:0] RGB_RED     = 12'hF00;
   localparam logic [11:0] RGB_BLUE    = 12'h00F;
   localparam logic [11:0] RGB_BLACK   = 12'h000;

   // Eight 100-pixel-wide vertical bars; a compare chain stands in for x/100.
   function automatic logic [11:0] bar_colour(input logic [CNT_W-1:0] x);
      logic [11:0] c;
      if (x < 11'd100)      c = RGB_WHITE;
      else if (x < 11'd200) c = RGB_YELLOW;
      else if (x < 11'd300) c = RGB_CYAN;
      else if (x < 11'd400) c = RGB_GREEN;
      else if (x < 11'd500) c = RGB_MAGENTA;
      else if (x < 11'd600) c = RGB_RED;
      else if (x < 11'd700) c = RGB_BLUE;
      else                  c = RGB_BLACK;
      return c;
   endfunction

endpackage

// File: rtl/vga_lock_filter.sv
// ----------------------------------------------------------------------------
// vga_lock_filter
// Qualifies the asynchronous PLL lock: 2-flop synchronizer, then an FSM that
// demands SETTLE_CLKS consecutive synchronized-high clocks before RUN.
// Ports:
//   clk_i   pixel clock
//   rst_ni  asynchronous active-low reset
//   lock_i  PLL lock, asynchronous to clk_i
//   run_o   1 while the FSM is in RUN (registered alongside the state)
// ----------------------------------------------------------------------------
module vga_lock_filter
   import vga_pkg::*;
#(
   parameter int SETTLE_CLKS = LOCK_SETTLE
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic lock_i,
   output logic run_o
);

   localparam int SW = $clog2(SETTLE_CLKS);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CLKS - 1);

   logic          sync1_q;
   logic          lock_s_q;
   lock_state_e   state_q;
   logic [SW-1:0] cnt_q;
   logic          run_q;

   // Two-stage synchronizer for the asynchronous lock input
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q  <= 1'b0;
         lock_s_q <= 1'b0;
      end else begin
         sync1_q  <= lock_i;
         lock_s_q <= sync1_q;
      end
   end

   // Lock-qualification FSM with settle counter; run_q tracks state == RUN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= WAIT_LOCK;
         cnt_q   <= {SW{1'b0}};
         run_q   <= 1'b0;
      end else begin
         case (state_q)
            WAIT_LOCK: begin
               cnt_q <= {SW{1'b0}};
               run_q <= 1'b0;
               if (lock_s_q) state_q <= SETTLE;
               else          state_q <= WAIT_LOCK;
            end
            SETTLE: begin
               if (!lock_s_q) begin
                  state_q <= WAIT_LOCK;
                  cnt_q   <= {SW{1'b0}};
                  run_q   <= 1'b0;
               end else if (cnt_q == SETTLE_LAST) begin
                  state_q <= RUN;
                  cnt_q   <= {SW{1'b0}};
                  run_q   <= 1'b1;
               end else begin
                  state_q <= SETTLE;
                  cnt_q   <= cnt_q + 1'b1;
                  run_q   <= 1'b0;
               end
            end
            RUN: begin
               cnt_q <= {SW{1'b0}};
               // lock loss abandons the raster wherever it is
               if (!lock_s_q) begin
                  state_q <= WAIT_LOCK;
                  run_q   <= 1'b0;
               end else begin
                  state_q <= RUN;
                  run_q   <= 1'b1;
               end
            end
            default: begin
               state_q <= WAIT_LOCK;
               cnt_q   <= {SW{1'b0}};
               run_q   <= 1'b0;
            end
         endcase
      end
   end

   assign run_o = run_q;

endmodule

// File: rtl/vga_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen
// SVGA raster timing generator (800x600@56 Hz defaults from vga_pkg). Raster
// starts at (0,0) once vga_lock_filter qualifies the PLL lock; every output is
// registered and idles (syncs inactive, counters 0) outside RUN.
// Optional macro VGA_TEST_PATTERN_EN adds a 12-bit colour-bar output rgb.
// Ports:
//   vga_clk      36 MHz pixel clock
//   rst_n        asynchronous active-low reset
//   lock         PLL lock, asynchronous
//   running      1 while raster output is live
//   hsync/vsync  syncs, active level HS_POL / VS_POL
//   de           active-video enable
//   pix_x/pix_y  current column / line
//   line_start   pulse at pix_x == 0
//   frame_start  pulse at pix_x == 0, pix_y == 0
//   rgb          (VGA_TEST_PATTERN_EN only) colour bars, 0 when de == 0
// ----------------------------------------------------------------------------
module vga_timing_gen #(
   parameter int   H_ACTIVE    = vga_pkg::H_ACTIVE,
   parameter int   H_FP        = vga_pkg::H_FP,
   parameter int   H_SYNC      = vga_pkg::H_SYNC,
   parameter int   H_BP        = vga_pkg::H_BP,
   parameter int   V_ACTIVE    = vga_pkg::V_ACTIVE,
   parameter int   V_FP        = vga_pkg::V_FP,
   parameter int   V_SYNC      = vga_pkg::V_SYNC,
   parameter int   V_BP        = vga_pkg::V_BP,
   parameter logic HS_POL      = vga_pkg::HS_POL,
   parameter logic VS_POL      = vga_pkg::VS_POL,
   parameter int   LOCK_SETTLE = vga_pkg::LOCK_SETTLE
) (
   input  logic                      vga_clk,
   input  logic                      rst_n,
   input  logic                      lock,
   output logic                      running,
   output logic                      hsync,
   output logic                      vsync,
   output logic                      de,
   output logic [vga_pkg::CNT_W-1:0] pix_x,
   output logic [vga_pkg::CNT_W-1:0] pix_y,
   output logic                      line_start,
   output logic                      frame_start
`ifdef VGA_TEST_PATTERN_EN
   ,
   output logic [11:0]               rgb
`endif
);

   import vga_pkg::*;

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

   logic             run_s;
   logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
   logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
   logic             de_s, hs_act_s, vs_act_s;

   vga_lock_filter #(
      .SETTLE_CLKS (LOCK_SETTLE)
   ) u_lock_filter (
      .clk_i  (vga_clk),
      .rst_ni (rst_n),
      .lock_i (lock),
      .run_o  (run_s)
   );

   // Raster counter next-state; held at the origin so RUN always begins at (0,0)
   always_comb begin
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      if (!run_s) begin
         h_cnt_d = {CNT_W{1'b0}};
         v_cnt_d = {CNT_W{1'b0}};
      end else if (h_cnt_q == H_LAST) begin
         h_cnt_d = {CNT_W{1'b0}};
         if (v_cnt_q == V_LAST) v_cnt_d = {CNT_W{1'b0}};
         else                   v_cnt_d = v_cnt_q + 1'b1;
      end else begin
         h_cnt_d = h_cnt_q + 1'b1;
      end
   end

   // Raster counter registers
   always_ff @(posedge vga_clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt_q <= {CNT_W{1'b0}};
         v_cnt_q <= {CNT_W{1'b0}};
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
      end
   end

   // Region decode of the current counter values
   always_comb begin
      de_s     = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
      hs_act_s = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
      vs_act_s = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
   end

   // Output register stage: every output samples the same counter values
   always_ff @(posedge vga_clk or negedge rst_n) begin
      if (!rst_n) begin
         running     <= 1'b0;
         hsync       <= ~HS_POL;
         vsync       <= ~VS_POL;
         de          <= 1'b0;
         pix_x       <= {CNT_W{1'b0}};
         pix_y       <= {CNT_W{1'b0}};
         line_start  <= 1'b0;
         frame_start <= 1'b0;
`ifdef VGA_TEST_PATTERN_EN
         rgb         <= 12'h000;
`endif
      end else if (!run_s) begin
         running     <= 1'b0;
         hsync       <= ~HS_POL;
         vsync       <= ~VS_POL;
         de          <= 1'b0;
         pix_x       <= {CNT_W{1'b0}};
         pix_y       <= {CNT_W{1'b0}};
         line_start  <= 1'b0;
         frame_start <= 1'b0;
`ifdef VGA_TEST_PATTERN_EN
         rgb         <= 12'h000;
`endif
      end else begin
         running     <= 1'b1;
         hsync       <= hs_act_s ? HS_POL : ~HS_POL;
         vsync       <= vs_act_s ? VS_POL : ~VS_POL;
         de          <= de_s;
         pix_x       <= h_cnt_q;
         pix_y       <= v_cnt_q;
         line_start  <= (h_cnt_q == {CNT_W{1'b0}});
         frame_start <= (h_cnt_q == {CNT_W{1'b0}}) && (v_cnt_q == {CNT_W{1'b0}});
`ifdef VGA_TEST_PATTERN_EN
         rgb         <= de_s ? bar_colour(h_cnt_q) : 12'h000;
`endif
      end
   end

endmodule
